// File: rtl/aes_pkg.sv
// Shared AES sequencer definitions: sizing constants, FSM state encoding and a
// round-key slicing helper used by the sequencer and its benches.
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_BLK_W = 128;
    localparam int AES_KEY_W = AES_BLK_W * (AES_NR + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } seq_state_e;

    function automatic logic [AES_BLK_W-1:0] rk_slice(input logic [AES_KEY_W-1:0] key,
                                                      input logic [3:0]           k);
        return key[AES_BLK_W*k +: AES_BLK_W];
    endfunction

endpackage

// File: rtl/aes_rk_mux.sv
// Combinational round-key selector: picks 128-bit round key rnd out of the
// expanded schedule; out-of-range round numbers select zero.
module aes_rk_mux #(
    parameter int BLK_W = 128,
    parameter int NR    = 10,
    parameter int KEY_W = BLK_W * (NR + 1)
) (
    input  logic [KEY_W-1:0] key,
    input  logic [3:0]       rnd,
    output logic [BLK_W-1:0] rd_key
);

    always_comb begin
        // NOTE: default first so every path assigns rd_key and no latch is inferred.
        rd_key = '0;
        for (int k = 0; k <= NR; k++) begin
            if (rnd == 4'(k)) rd_key = key[BLK_W*k +: BLK_W];
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encrypt controller driving an external round datapath.
// Optional macro AES_SEQ_ABORT_EN adds an abort input that drops the block in flight.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR    = AES_NR,
    parameter int BLK_W = AES_BLK_W,
    parameter int KEY_W = BLK_W * (NR + 1)
) (
    input  logic             clk,
    input  logic             rst,
`ifdef AES_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic [KEY_W-1:0] key,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic [BLK_W-1:0] rd_state,
    output logic [BLK_W-1:0] rd_key,
    output logic [3:0]       rd_num,
    output logic             rd_last,
    input  logic [BLK_W-1:0] rd_result,
    output logic             busy
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    seq_state_e       fsm_q;
    logic [3:0]       rnd_q;
    logic [BLK_W-1:0] state_q;
    logic [BLK_W-1:0] sel_key;
    logic             abort_req;
    logic             in_round;

`ifdef AES_SEQ_ABORT_EN
    assign abort_req = abort && (fsm_q != IDLE);
`else
    assign abort_req = 1'b0;
`endif

    aes_rk_mux #(
        .BLK_W (BLK_W),
        .NR    (NR),
        .KEY_W (KEY_W)
    ) u_rk_mux (
        .key    (key),
        .rnd    (rnd_q),
        .rd_key (sel_key)
    );

    assign in_round  = (fsm_q == ROUND);
    // A new block may enter from DONE only when the current result leaves in the same cycle.
    assign in_ready  = (fsm_q == IDLE) || ((fsm_q == DONE) && out_ready && !abort_req);
    assign out_valid = (fsm_q == DONE);
    assign out_data  = state_q;
    assign busy      = (fsm_q != IDLE);
    assign rd_state  = in_round ? state_q : '0;
    assign rd_key    = in_round ? sel_key : '0;
    assign rd_num    = in_round ? rnd_q : 4'd0;
    assign rd_last   = in_round && (rnd_q == LAST_RND);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q   <= IDLE;
            rnd_q   <= 4'd0;
            state_q <= '0;
        end else if (abort_req) begin
            fsm_q <= IDLE;
            rnd_q <= 4'd0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= in_data ^ key[BLK_W-1:0];
                        rnd_q   <= 4'd1;
                        fsm_q   <= ROUND;
                    end
                end
                ROUND: begin
                    state_q <= rd_result;
                    if (rnd_q == LAST_RND) begin
                        rnd_q <= 4'd0;
                        fsm_q <= DONE;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            state_q <= in_data ^ key[BLK_W-1:0];
                            rnd_q   <= 4'd1;
                            fsm_q   <= ROUND;
                        end else begin
                            fsm_q <= IDLE;
                        end
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer with a behavioural AES round datapath
// and key expansion; AES_SEQ_ABORT_EN enables the abort scenario.
module tb_aes_round_sequencer;
    import aes_pkg::*;

    logic                 clk;
    logic                 rst;
    logic [AES_KEY_W-1:0] key;
    logic                 in_valid;
    logic                 in_ready;
    logic [AES_BLK_W-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [AES_BLK_W-1:0] out_data;
    logic [AES_BLK_W-1:0] rd_state;
    logic [AES_BLK_W-1:0] rd_key;
    logic [3:0]           rd_num;
    logic                 rd_last;
    logic [AES_BLK_W-1:0] rd_result;
    logic                 busy;
`ifdef AES_SEQ_ABORT_EN
    logic                 abort;
`endif

    int errors = 0;
    int checks = 0;

    aes_round_sequencer dut (
        .clk       (clk),
        .rst       (rst),
`ifdef AES_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .key       (key),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rd_state  (rd_state),
        .rd_key    (rd_key),
        .rd_num    (rd_num),
        .rd_last   (rd_last),
        .rd_result (rd_result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        logic [7:0] b = x;
        logic [7:0] s;
        for (int e = 0; e < 8; e++) begin
            if (e != 0) r = gmul(r, b);
            b = gmul(b, b);
        end
        s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++) t[rw+4*c] = b[rw + 4*((c+rw)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                logic [7:0] a0, a1, a2, a3;
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
        return r ^ k;
    endfunction

    function automatic logic [AES_KEY_W-1:0] expand(input logic [127:0] k);
        logic [31:0]          w [44];
        logic [31:0]          tmp;
        logic [7:0]           rcon = 8'h01;
        logic [AES_KEY_W-1:0] sched;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])}
                      ^ {rcon, 24'h000000};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= AES_NR; r++) sched[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return sched;
    endfunction

    assign rd_result = aes_round(rd_state, rd_key, rd_last);

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        key       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef AES_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        step();
        check("reset out_valid", 128'(out_valid), 128'd0);
        check("reset busy", 128'(busy), 128'd0);
        check("reset rd_num", 128'(rd_num), 128'd0);
        check("reset rd_last", 128'(rd_last), 128'd0);
        check("reset in_ready", 128'(in_ready), 128'd1);
        check("reset out_data", out_data, 128'd0);
        check("reset rd_key", rd_key, 128'd0);
        @(negedge clk);
        rst = 1'b1;

        // FIPS-197 C.1 with datapath monitor; in_valid held high in ROUND must be ignored.
        key      = expand(128'h000102030405060708090a0b0c0d0e0f);
        in_valid = 1'b1;
        in_data  = 128'h00112233445566778899aabbccddeeff;
        step();
        in_data = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        for (int r = 1; r <= 10; r++) begin
            check($sformatf("c1 rd_num r%0d", r), 128'(rd_num), 128'(r));
            check($sformatf("c1 rd_last r%0d", r), 128'(rd_last), 128'(r == 10));
            check($sformatf("c1 rd_key r%0d", r), rd_key, rk_slice(key, 4'(r)));
            check($sformatf("c1 in_ready r%0d", r), 128'(in_ready), 128'd0);
            check($sformatf("c1 out_valid r%0d", r), 128'(out_valid), 128'd0);
            step();
        end
        check("c1 out_valid", 128'(out_valid), 128'd1);
        check("c1 out_data", out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        check("c1 rd_num done", 128'(rd_num), 128'd0);
        check("c1 rd_state done", rd_state, 128'd0);

        // Output stall: result holds, nothing accepted.
        for (int i = 0; i < 20; i++) begin
            in_data = {4{$urandom}};
            check($sformatf("stall out_valid c%0d", i), 128'(out_valid), 128'd1);
            check($sformatf("stall out_data c%0d", i), out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
            check($sformatf("stall in_ready c%0d", i), 128'(in_ready), 128'd0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("drain in_ready", 128'(in_ready), 128'd1);
        step();
        check("drain out_valid", 128'(out_valid), 128'd0);
        check("drain busy", 128'(busy), 128'd0);

        // Back-to-back: SP800-38A ECB vectors under key 2b7e...
        key      = expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        in_valid = 1'b1;
        in_data  = 128'h6bc1bee22e409f96e93d7e117393172a;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        check("b2b first valid", 128'(out_valid), 128'd1);
        check("b2b first data", out_data, 128'h3ad77bb40d7a3660a89ecaf32466ef97);
        in_valid = 1'b1;
        in_data  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        #1;
        check("b2b in_ready done", 128'(in_ready), 128'd1);
        step();
        in_valid = 1'b0;
        check("b2b rd_num", 128'(rd_num), 128'd1);
        check("b2b out_valid gap", 128'(out_valid), 128'd0);
        repeat (10) step();
        check("b2b second valid", 128'(out_valid), 128'd1);
        check("b2b second data", out_data, 128'hf5d3d58503b9699de785895a96fdbaaf);
        step();
        check("b2b idle", 128'(busy), 128'd0);

        // Asynchronous reset at round 5, then a fresh block (FIPS-197 B).
        in_valid = 1'b1;
        in_data  = 128'h00000000111111112222222233333333;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        check("rst rd_num before", 128'(rd_num), 128'd5);
        #2;
        rst = 1'b0;
        #1;
        check("rst busy", 128'(busy), 128'd0);
        check("rst rd_num", 128'(rd_num), 128'd0);
        check("rst out_valid", 128'(out_valid), 128'd0);
        check("rst in_ready", 128'(in_ready), 128'd1);
        check("rst out_data", out_data, 128'd0);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 128'h3243f6a8885a308d313198a2e0370734;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        check("post-rst valid", 128'(out_valid), 128'd1);
        check("post-rst data", out_data, 128'h3925841d02dc09fbdc118597196a0b32);
        step();

`ifdef AES_SEQ_ABORT_EN
        // Abort at round 3 drops the block; the next block completes normally.
        in_valid = 1'b1;
        in_data  = 128'h6bc1bee22e409f96e93d7e117393172a;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        check("abort rd_num", 128'(rd_num), 128'd3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort busy", 128'(busy), 128'd0);
        check("abort rd_num after", 128'(rd_num), 128'd0);
        check("abort in_ready", 128'(in_ready), 128'd1);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("abort no out_valid c%0d", i), 128'(out_valid), 128'd0);
            step();
        end
        in_valid = 1'b1;
        in_data  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        check("abort next valid", 128'(out_valid), 128'd1);
        check("abort next data", out_data, 128'hf5d3d58503b9699de785895a96fdbaaf);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
